// File: rtl/reorder_buffer.sv
// In-order retirement buffer: entries are allocated at issue, completed by the CDB in any
// order, and retired from the head through a combinational register-file write port.
module reorder_buffer #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 3,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_rd,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    input  logic [TAG_W-1:0] q1_tag,
    output logic             q1_done,
    output logic [XLEN-1:0]  q1_value,
    input  logic [TAG_W-1:0] q2_tag,
    output logic             q2_done,
    output logic [XLEN-1:0]  q2_value,
    output logic             RegWrite,
    output logic [4:0]       writeaddr,
    output logic [XLEN-1:0]  writedata,
    output logic             empty
);

    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    logic            valid_q [DEPTH];
    logic            valid_d [DEPTH];
    logic            done_q  [DEPTH];
    logic            done_d  [DEPTH];
    logic [4:0]      rd_q    [DEPTH];
    logic [4:0]      rd_d    [DEPTH];
    logic [XLEN-1:0] value_q [DEPTH];
    logic [XLEN-1:0] value_d [DEPTH];

    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    logic commit;
    logic alloc_fire;
    logic q1_bypass;
    logic q2_bypass;

    // alloc_ready is based on the registered count only, so a same-cycle retire cannot
    // open a slot for an allocation.
    assign alloc_ready = (count_q < FULL_CNT);
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign alloc_tag   = tail_q;
    assign empty       = (count_q == '0);

    assign commit    = valid_q[head_q] & done_q[head_q];
    assign RegWrite  = commit & (rd_q[head_q] != 5'd0);
    assign writeaddr = rd_q[head_q];
    assign writedata = value_q[head_q];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic alloc_hit;
            logic commit_hit;
            logic cdb_hit;

            assign alloc_hit  = alloc_fire && (tail_q == TAG_W'(gi));
            assign commit_hit = commit && (head_q == TAG_W'(gi));
            assign cdb_hit    = cdb_valid && (cdb_tag == TAG_W'(gi)) && valid_q[gi];

            // An allocating index is never valid, so alloc and CDB never collide here.
            assign valid_d[gi] = alloc_hit ? 1'b1 : (commit_hit ? 1'b0 : valid_q[gi]);
            assign done_d[gi]  = (alloc_hit || commit_hit) ? 1'b0 : (cdb_hit ? 1'b1 : done_q[gi]);
            assign rd_d[gi]    = alloc_hit ? alloc_rd : rd_q[gi];
            assign value_d[gi] = cdb_hit ? cdb_data : value_q[gi];
        end
    endgenerate

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (commit) begin
            head_d = head_q + 1'b1;
        end
        if (alloc_fire) begin
            tail_d = tail_q + 1'b1;
        end
        if (alloc_fire && !commit) begin
            count_d = count_q + 1'b1;
        end else if (!alloc_fire && commit) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                done_q[i]  <= 1'b0;
                rd_q[i]    <= '0;
                value_q[i] <= '0;
            end
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                done_q[i]  <= 1'b0;
                rd_q[i]    <= '0;
                value_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= valid_d[i];
                done_q[i]  <= done_d[i];
                rd_q[i]    <= rd_d[i];
                value_q[i] <= value_d[i];
            end
        end
    end

    // Operand lookup forwards a same-cycle CDB result ahead of the stored value.
    assign q1_bypass = cdb_valid && (cdb_tag == q1_tag) && valid_q[q1_tag];
    assign q1_done   = q1_bypass | (valid_q[q1_tag] & done_q[q1_tag]);
    assign q1_value  = q1_bypass ? cdb_data : value_q[q1_tag];

    assign q2_bypass = cdb_valid && (cdb_tag == q2_tag) && valid_q[q2_tag];
    assign q2_done   = q2_bypass | (valid_q[q2_tag] & done_q[q2_tag]);
    assign q2_value  = q2_bypass ? cdb_data : value_q[q2_tag];

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: a small entry model feeds a queue of expected register-file
// writes, which a negedge monitor pops and compares on every RegWrite pulse.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        alloc_valid = 1'b0;
    logic [4:0]  alloc_rd = '0;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        cdb_valid = 1'b0;
    logic [2:0]  cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic [2:0]  q1_tag = '0;
    logic        q1_done;
    logic [31:0] q1_value;
    logic [2:0]  q2_tag = '0;
    logic        q2_done;
    logic [31:0] q2_value;
    logic        RegWrite;
    logic [4:0]  writeaddr;
    logic [31:0] writedata;
    logic        empty;

    int n_checks = 0;
    int n_fail   = 0;

    // Bench-side entry model and expected write queue {addr, data}
    logic [4:0]  m_rd    [8];
    logic [31:0] m_val   [8];
    bit          m_valid [8];
    bit          m_done  [8];
    int          m_head = 0;
    int          m_tail = 0;
    logic [36:0] exp_q [$];

    reorder_buffer #(.DEPTH(8), .TAG_W(3), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .q1_tag(q1_tag), .q1_done(q1_done), .q1_value(q1_value),
        .q2_tag(q2_tag), .q2_done(q2_done), .q2_value(q2_value),
        .RegWrite(RegWrite), .writeaddr(writeaddr), .writedata(writedata),
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_clear();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_done[i]  = 1'b0;
        end
        m_head = 0;
        m_tail = 0;
    endtask

    task automatic m_drain();
        while (m_valid[m_head] && m_done[m_head]) begin
            if (m_rd[m_head] != 5'd0) exp_q.push_back({m_rd[m_head], m_val[m_head]});
            m_valid[m_head] = 1'b0;
            m_done[m_head]  = 1'b0;
            m_head = (m_head + 1) % 8;
        end
    endtask

    task automatic do_alloc(input logic [4:0] rd, input bit accept);
        alloc_valid = 1'b1;
        alloc_rd    = rd;
        if (accept) begin
            check("alloc_tag", 64'(alloc_tag), 64'(m_tail));
            m_valid[m_tail] = 1'b1;
            m_done[m_tail]  = 1'b0;
            m_rd[m_tail]    = rd;
            $display("alloc rd=%0d tag=%0d", rd, m_tail);
            m_tail = (m_tail + 1) % 8;
        end else begin
            $display("alloc rd=%0d dropped", rd);
        end
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_cdb(input logic [2:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
        if (m_valid[tag]) begin
            m_val[tag]  = data;
            m_done[tag] = 1'b1;
        end
        m_drain();
        $display("cdb tag=%0d data=0x%0h", tag, data);
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while (!empty && n < 20) begin
            tick();
            n++;
        end
        check(tag, 64'(empty), 64'(1));
    endtask

    always @(negedge clk) begin
        if (!rst && RegWrite) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(writeaddr), 64'(0));
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("writeaddr", 64'(writeaddr), 64'(e[36:32]));
                check("writedata", 64'(writedata), 64'(e[31:0]));
                $display("commit x%0d = 0x%0h", writeaddr, writedata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_clear();
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_alloc_ready", 64'(alloc_ready), 64'(1));
        check("rst_alloc_tag",   64'(alloc_tag),   64'(0));
        check("rst_regwrite",    64'(RegWrite),    64'(0));
        check("rst_empty",       64'(empty),       64'(1));
        check("rst_writeaddr",   64'(writeaddr),   64'(0));
        check("rst_writedata",   64'(writedata),   64'(0));

        // Fill the ROB; the ninth request is dropped
        for (int i = 0; i < 8; i++) begin
            check("fill_ready", 64'(alloc_ready), 64'(1));
            do_alloc(5'(i + 1), 1'b1);
        end
        check("full_ready", 64'(alloc_ready), 64'(0));
        check("full_empty", 64'(empty), 64'(0));
        do_alloc(5'd9, 1'b0);
        check("drop_tail", 64'(alloc_tag), 64'(0));
        check("drop_ready", 64'(alloc_ready), 64'(0));

        // Out-of-order completion, in-order retirement
        do_cdb(3'd2, 32'hA);
        check("ooo_no_commit_2", 64'(RegWrite), 64'(0));
        do_cdb(3'd1, 32'hB);
        check("ooo_no_commit_1", 64'(RegWrite), 64'(0));
        do_cdb(3'd0, 32'hC);
        check("ret0_we",   64'(RegWrite),  64'(1));
        check("ret0_addr", 64'(writeaddr), 64'(1));
        tick();
        check("ret1_we",   64'(RegWrite),  64'(1));
        check("ret1_addr", 64'(writeaddr), 64'(2));
        tick();
        check("ret2_addr", 64'(writeaddr), 64'(3));
        tick();
        check("ret_stop",  64'(RegWrite),  64'(0));
        for (int t = 3; t < 8; t++) do_cdb(3'(t), 32'h100 + 32'(t));
        wait_empty("drain_empty");

        // rd = 0 retires silently
        do_alloc(5'd0, 1'b1);
        do_alloc(5'd5, 1'b1);
        do_cdb(3'd0, 32'h11);
        check("x0_we",   64'(RegWrite),  64'(0));
        check("x0_addr", 64'(writeaddr), 64'(0));
        do_cdb(3'd1, 32'h22);
        check("x5_we",   64'(RegWrite),  64'(1));
        check("x5_addr", 64'(writeaddr), 64'(5));
        check("x5_data", 64'(writedata), 64'(32'h22));
        tick();
        check("x5_empty", 64'(empty), 64'(1));
        check("x5_ready", 64'(alloc_ready), 64'(1));

        flush = 1'b1;
        tick();
        flush = 1'b0;
        m_clear();
        check("flush0_tag", 64'(alloc_tag), 64'(0));

        // Full ROB with the head retiring: the same-cycle alloc is dropped
        for (int i = 0; i < 8; i++) do_alloc(5'(i + 1), 1'b1);
        do_cdb(3'd0, 32'h77);
        check("fullc_we", 64'(RegWrite), 64'(1));
        alloc_valid = 1'b1;
        alloc_rd    = 5'd9;
        check("fullc_ready", 64'(alloc_ready), 64'(0));
        tick();
        alloc_valid = 1'b0;
        check("after_ready", 64'(alloc_ready), 64'(1));
        check("after_tag",   64'(alloc_tag),   64'(0));
        do_alloc(5'd9, 1'b1);
        check("refull_ready", 64'(alloc_ready), 64'(0));

        // Lookup bypass, then the same value from storage
        q1_tag    = 3'd3;
        q2_tag    = 3'd4;
        cdb_valid = 1'b1;
        cdb_tag   = 3'd3;
        cdb_data  = 32'h55;
        m_val[3]  = 32'h55;
        m_done[3] = 1'b1;
        m_drain();
        #1;
        check("byp_done",   64'(q1_done),  64'(1));
        check("byp_value",  64'(q1_value), 64'(32'h55));
        check("byp_q2_done", 64'(q2_done), 64'(0));
        tick();
        cdb_valid = 1'b0;
        q2_tag    = 3'd3;
        #1;
        check("store_done",  64'(q1_done),  64'(1));
        check("store_value", 64'(q1_value), 64'(32'h55));
        check("store_q2",    64'(q2_value), 64'(32'h55));

        // Asynchronous reset with four done entries behind an incomplete head
        do_cdb(3'd4, 32'h44);
        do_cdb(3'd5, 32'h45);
        do_cdb(3'd6, 32'h46);
        check("pre_rst_we", 64'(RegWrite), 64'(0));
        rst = 1'b1;
        #1;
        check("arst_we",    64'(RegWrite),    64'(0));
        check("arst_empty", 64'(empty),       64'(1));
        check("arst_tag",   64'(alloc_tag),   64'(0));
        check("arst_ready", 64'(alloc_ready), 64'(1));
        tick();
        tick();
        rst = 1'b0;
        m_clear();
        tick();
        check("arst_q1_done", 64'(q1_done), 64'(0));
        check("arst_we2",     64'(RegWrite), 64'(0));

        // Flush wins over a simultaneous alloc and CDB write
        for (int i = 0; i < 3; i++) do_alloc(5'(i + 1), 1'b1);
        do_cdb(3'd1, 32'h61);
        do_cdb(3'd2, 32'h62);
        flush       = 1'b1;
        alloc_valid = 1'b1;
        alloc_rd    = 5'd7;
        cdb_valid   = 1'b1;
        cdb_tag     = 3'd0;
        cdb_data    = 32'h60;
        tick();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        cdb_valid   = 1'b0;
        m_clear();
        q1_tag = 3'd1;
        #1;
        check("flush_empty", 64'(empty),     64'(1));
        check("flush_tag",   64'(alloc_tag), 64'(0));
        check("flush_we",    64'(RegWrite),  64'(0));
        check("flush_q1",    64'(q1_done),   64'(0));
        tick();
        check("flush_we2",   64'(RegWrite),  64'(0));
        check("sb_empty",    64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
